// File: rtl/fft_ctrl.sv
// -----------------------------------------------------------------------------
// fft_ctrl
//
// Sequencer for an in-place radix-2 DIT FFT engine built around one shared
// butterfly unit and a CORDIC twiddle rotator. A frame passes through:
//   LOAD   - N input samples written to RAM in bit-reversed address order
//   CALC   - LOG2N stages of N/2 butterflies, one req/ack handshake each
//   GAP    - one idle cycle between stages so the last write-back settles
//   UNLOAD - N bins streamed out in natural order
// The controller holds no sample data. It only generates RAM addresses and
// twiddle indices.
//
// Optional feature: define FFT_CTRL_INVERSE_EN to latch 'inv' on an accepted
// start and drive it on tw_dir for the whole frame. Without the macro, 'inv'
// is ignored and tw_dir is tied to 0, so only the forward FFT is available.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-low reset
//   start, inv      frame start (sampled in IDLE); inverse-transform request
//   busy, done      high outside IDLE; one-cycle pulse after the last bin
//   in_valid        input sample present
//   in_ready        high in LOAD
//   wr_en, wr_addr  sample write strobe and bit-reversed write address
//   bf_req, bf_ack  butterfly handshake; addr_a/addr_b/tw_idx/tw_dir are
//                   stable while bf_req is high
//   addr_a, addr_b  upper and lower butterfly operand addresses
//   tw_idx, tw_dir  twiddle index k and conjugate flag
//   stage           current FFT stage
//   out_valid       high in UNLOAD
//   out_ready       downstream accepts the current bin
//   rd_addr         natural-order bin index
//   out_last        marks bin N-1
// -----------------------------------------------------------------------------
module fft_ctrl #(
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inv,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr,
  output logic             bf_req,
  input  logic             bf_ack,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             tw_dir,
  output logic [LOG2N-1:0] stage,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] rd_addr,
  output logic             out_last
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CALC   = 3'd2,
    GAP    = 3'd3,
    UNLOAD = 3'd4
  } state_t;

  localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
  localparam logic [LOG2N-2:0] LAST_BF    = (LOG2N - 1)'(N / 2 - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);

  state_t           state;
  logic [LOG2N-1:0] lcnt;     // load beat counter
  logic [LOG2N-2:0] bcnt;     // butterfly counter within a stage
  logic [LOG2N-1:0] stage_q;
  logic [LOG2N-1:0] rcnt;     // unload beat counter
  logic             done_q;

  // ---------------------------------------------------------------------------
  // Moore decodes of the registered state.
  // ---------------------------------------------------------------------------
  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign wr_en     = in_valid & in_ready;
  assign bf_req    = (state == CALC);
  assign out_valid = (state == UNLOAD);
  assign out_last  = out_valid & (rcnt == LAST_IDX);
  assign rd_addr   = rcnt;
  assign stage     = stage_q;
  assign done      = done_q;

  // Bit-reversed load address.
  // NOTE: every always_comb output gets a default before any conditional
  // logic, so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      wr_addr[i] = lcnt[LOG2N-1-i];
    end
  end

  // Butterfly addressing for butterfly b of stage s, with half = 2^s:
  //   addr_a = ((b >> s) << (s+1)) | (b & (half-1))
  //   addr_b = addr_a + half
  //   tw_idx = (b & (half-1)) << (LOG2N-1-s)
  // The mask is built at the width of b. In the last stage, 1 << s wraps to 0
  // at that width, so the mask becomes all ones, which is the required value.
  logic [LOG2N-2:0] low_mask;
  logic [LOG2N-2:0] low_b;
  logic [LOG2N-1:0] a_calc;
  logic [LOG2N-1:0] half;

  always_comb begin
    low_mask = ((LOG2N - 1)'(1) << stage_q) - (LOG2N - 1)'(1);
    low_b    = bcnt & low_mask;
    half     = LOG2N'(1) << stage_q;
    a_calc   = ((LOG2N'(bcnt) >> stage_q) << (stage_q + LOG2N'(1)))
               | LOG2N'(low_b);
    addr_a   = '0;
    addr_b   = '0;
    tw_idx   = '0;
    // Addresses are driven only while a butterfly is requested, so the
    // outputs are zero after reset and between stages.
    if (state == CALC) begin
      addr_a = a_calc;
      addr_b = a_calc + half;
      tw_idx = low_b << (LAST_STAGE - stage_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples its pre-edge value and simulation matches hardware.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lcnt    <= '0;
      bcnt    <= '0;
      stage_q <= '0;
      rcnt    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (wr_en) begin
            if (lcnt == LAST_IDX) begin
              lcnt  <= '0;
              state <= CALC;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
        end
        CALC: begin
          if (bf_ack) begin
            if (bcnt == LAST_BF) begin
              bcnt  <= '0;
              state <= GAP;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (stage_q == LAST_STAGE) begin
            stage_q <= '0;
            state   <= UNLOAD;
          end else begin
            stage_q <= stage_q + 1'b1;
            state   <= CALC;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (rcnt == LAST_IDX) begin
              rcnt   <= '0;
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFT_CTRL_INVERSE_EN
  // The transform direction is captured once per frame when start is accepted.
  logic tw_dir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tw_dir_q <= 1'b0;
    end else if (state == IDLE && start) begin
      tw_dir_q <= inv;
    end
  end

  assign tw_dir = tw_dir_q;
`else
  // Forward-only build: inv has no effect.
  logic unused_inv;
  assign unused_inv = inv;
  assign tw_dir     = 1'b0;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_ctrl
//
// Directed bench for fft_ctrl with N=8 and LOG2N=3. It covers:
//   - the reset state of every output
//   - a stall-free frame with inv=1: load order, butterfly address/twiddle
//     table, inter-stage gap, unload order and frame length
//   - a back-to-back frame with input, butterfly-ack and output stalls
//   - reset asserted during CALC stage 1, followed by a fresh frame
// -----------------------------------------------------------------------------
module tb_fft_ctrl;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, inv, in_valid, bf_ack, out_ready;
  logic       busy, done, in_ready, wr_en, bf_req, tw_dir, out_valid, out_last;
  logic [2:0] wr_addr, addr_a, addr_b, stage, rd_addr;
  logic [1:0] tw_idx;

  fft_ctrl #(.N(N), .LOG2N(LOG2N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inv       (inv),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .bf_req    (bf_req),
    .bf_ack    (bf_ack),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .tw_dir    (tw_dir),
    .stage     (stage),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_addr   (rd_addr),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Hand-computed reference tables.
  logic [2:0] exp_wr [0:7]  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  logic [2:0] exp_a  [0:11] = '{3'd0, 3'd2, 3'd4, 3'd6,  3'd0, 3'd1, 3'd4, 3'd5,
                                3'd0, 3'd1, 3'd2, 3'd3};
  logic [2:0] exp_b  [0:11] = '{3'd1, 3'd3, 3'd5, 3'd7,  3'd2, 3'd3, 3'd6, 3'd7,
                                3'd4, 3'd5, 3'd6, 3'd7};
  logic [1:0] exp_k  [0:11] = '{2'd0, 2'd0, 2'd0, 2'd0,  2'd0, 2'd2, 2'd0, 2'd2,
                                2'd0, 2'd1, 2'd2, 2'd3};

  // Frame length from start acceptance to done, with no stalls.
  localparam int FRAME_CYC = N + (N / 2) * LOG2N + LOG2N + N;

`ifdef FFT_CTRL_INVERSE_EN
  localparam logic EXP_DIR_INV = 1'b1;
`else
  localparam logic EXP_DIR_INV = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return {busy, done, in_ready, wr_en, wr_addr, bf_req, addr_a, addr_b,
            tw_idx, tw_dir, stage, out_valid, rd_addr, out_last};
  endfunction

  int t0;
  int beats;
  int rexp;

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    inv       = 1'b0;
    in_valid  = 1'b0;
    bf_ack    = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("reset_outputs", all_outputs(), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // ---------------- frame 1: no stalls, inv=1 ----------------
    in_valid  = 1'b1;
    bf_ack    = 1'b1;  // also held high outside CALC, where it must be ignored
    out_ready = 1'b1;
    start     = 1'b1;
    inv       = 1'b1;
    tick();
    t0    = cyc;
    start = 1'b0;
    inv   = 1'b0;
    check("f1_busy", {31'd0, busy}, 32'd1);
    check("f1_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("f1_wr_en%0d", i), {31'd0, wr_en}, 32'd1);
      check($sformatf("f1_wr_addr%0d", i), {29'd0, wr_addr}, {29'd0, exp_wr[i]});
      tick();
    end
    check("f1_in_ready_drop", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("f1_bf_req%0d", i), {31'd0, bf_req}, 32'd1);
      check($sformatf("f1_addr_a%0d", i), {29'd0, addr_a}, {29'd0, exp_a[i]});
      check($sformatf("f1_addr_b%0d", i), {29'd0, addr_b}, {29'd0, exp_b[i]});
      check($sformatf("f1_tw_idx%0d", i), {30'd0, tw_idx}, {30'd0, exp_k[i]});
      check($sformatf("f1_stage%0d", i), {29'd0, stage}, i / 4);
      check($sformatf("f1_tw_dir%0d", i), {31'd0, tw_dir}, {31'd0, EXP_DIR_INV});
      tick();
      if (i % 4 == 3) begin
        check($sformatf("f1_gap%0d", i / 4), {31'd0, bf_req}, 32'd0);
        tick();
      end
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("f1_out_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("f1_rd_addr%0d", i), {29'd0, rd_addr}, i);
      check($sformatf("f1_out_last%0d", i), {31'd0, out_last}, (i == 7) ? 32'd1 : 32'd0);
      check($sformatf("f1_done_early%0d", i), {31'd0, done}, 32'd0);
      tick();
    end
    check("f1_done", {31'd0, done}, 32'd1);
    check("f1_idle", {31'd0, busy}, 32'd0);
    check("f1_frame_cycles", cyc - t0, FRAME_CYC);

    // ---------------- frame 2: start in done cycle, with stalls ----------------
    start     = 1'b1;
    inv       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    check("f2_done_pulse_end", {31'd0, done}, 32'd0);
    check("f2_back_to_back", {31'd0, in_ready}, 32'd1);
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      in_valid = (c % 2 == 1);
      #1;
      check($sformatf("f2_wr_en_c%0d", c), {31'd0, wr_en}, {31'd0, in_valid});
      check($sformatf("f2_wr_addr_c%0d", c), {29'd0, wr_addr}, {29'd0, exp_wr[beats]});
      if (in_valid) beats++;
      tick();
    end
    check("f2_load_beats", beats, 8);
    check("f2_in_ready_drop", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      for (int w = 0; w < 4; w++) begin
        bf_ack = (w == 3);
        #1;
        check($sformatf("f2_req%0d_%0d", i, w), {31'd0, bf_req}, 32'd1);
        check($sformatf("f2_addr_a%0d_%0d", i, w), {29'd0, addr_a}, {29'd0, exp_a[i]});
        check($sformatf("f2_addr_b%0d_%0d", i, w), {29'd0, addr_b}, {29'd0, exp_b[i]});
        check($sformatf("f2_tw_idx%0d_%0d", i, w), {30'd0, tw_idx}, {30'd0, exp_k[i]});
        check($sformatf("f2_tw_dir%0d_%0d", i, w), {31'd0, tw_dir}, 32'd0);
        tick();
      end
      if (i % 4 == 3) begin
        check($sformatf("f2_gap%0d", i / 4), {31'd0, bf_req}, 32'd0);
        tick();
      end
    end
    rexp = 0;
    for (int c = 0; c < 40 && rexp < 8; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      check($sformatf("f2_out_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("f2_rd_addr_c%0d", c), {29'd0, rd_addr}, rexp);
      check($sformatf("f2_out_last_c%0d", c), {31'd0, out_last}, (rexp == 7) ? 32'd1 : 32'd0);
      if (out_ready) rexp++;
      tick();
    end
    check("f2_unload_beats", rexp, 8);
    check("f2_done", {31'd0, done}, 32'd1);
    tick();
    check("f2_done_one_cycle", {31'd0, done}, 32'd0);
    check("f2_idle", {31'd0, busy}, 32'd0);

    // ---------------- frame 3: reset in CALC stage 1 ----------------
    in_valid = 1'b1;
    bf_ack   = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    repeat (5) tick();  // four stage-0 butterflies plus the gap
    check("f3_in_stage1", {29'd0, stage}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check("f3_reset_outputs", all_outputs(), 32'd0);
    tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("f3_restart_wr_en", {31'd0, wr_en}, 32'd1);
    check("f3_restart_wr_addr0", {29'd0, wr_addr}, 32'd0);
    tick();
    check("f3_restart_wr_addr1", {29'd0, wr_addr}, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
